// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller and the pipe registers it steers.
// Sequencer states, the zero-register index, and the nop word loaded on flush/bubble.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StMulti = 2'd2
    } state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register the IF_ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       hazard_o
);

    // Loads into the zero register never create a real dependency.
    assign hazard_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline sequencer: PC gating, IF_ID stall/flush, ID/EX and EX/MEM bubbles.
// Multi-cycle EX support (MULTI state, down-counter) is built only with PIPE_MULTICYCLE_EN.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic       ex_multi_i,
    input  logic       branch_taken_i,
    output logic       pc_write_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_bubble_o,
    output logic       ex_hold_o,
    output logic       ex_bubble_o,
    output logic       busy_o
);

    state_e state_q, state_d;
    logic   hazard;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .hazard_o       (hazard)
    );

    // Normal RUN flow: a load-use stall masks a simultaneous taken branch.
    logic run_pc_write, run_stall, run_flush, run_bubble;

    always_comb begin
        run_pc_write = 1'b1;
        run_stall    = 1'b0;
        run_flush    = 1'b0;
        run_bubble   = 1'b0;
        if (hazard) begin
            run_pc_write = 1'b0;
            run_stall    = 1'b1;
            run_bubble   = 1'b1;
        end else if (branch_taken_i) begin
            run_flush    = 1'b1;
        end
    end

`ifdef PIPE_MULTICYCLE_EN
    localparam logic [3:0] CntInit = 4'(MUL_LAT - 2);

    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_mul_lat = MUL_LAT;
    logic unused_ex_multi;
    assign unused_ex_multi = ex_multi_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
`ifdef PIPE_MULTICYCLE_EN
        cnt_d          = cnt_q;
`endif
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_hold_o      = 1'b0;
        ex_bubble_o    = 1'b0;
        busy_o         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if_id_stall_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                pc_write_o     = run_pc_write;
                if_id_stall_o  = run_stall;
                if_id_flush_o  = run_flush;
                id_ex_bubble_o = run_bubble;
`ifdef PIPE_MULTICYCLE_EN
                if (ex_multi_i) begin
                    pc_write_o     = 1'b0;
                    if_id_stall_o  = 1'b1;
                    if_id_flush_o  = 1'b0;
                    id_ex_bubble_o = 1'b0;
                    ex_hold_o      = 1'b1;
                    ex_bubble_o    = 1'b1;
                    cnt_d          = CntInit;
                    state_d        = StMulti;
                end
`endif
            end
`ifdef PIPE_MULTICYCLE_EN
            StMulti: begin
                busy_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    if_id_stall_o = 1'b1;
                    ex_hold_o     = 1'b1;
                    ex_bubble_o   = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                end else begin
                    // Op leaves EX this cycle; ID-stage hazards resolve as in RUN.
                    pc_write_o     = run_pc_write;
                    if_id_stall_o  = run_stall;
                    if_id_flush_o  = run_flush;
                    id_ex_bubble_o = run_bubble;
                    state_d        = StRun;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized scoreboard bench for pipeline_controller with a cycle-level behavioural model.
// The model tracks only "running" and "busy cycles left"; expected outputs are queued per cycle.
module tb_pipeline_controller;

    localparam int unsigned MulLat = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [4:0] ifid_rs_i = '0;
    logic [4:0] ifid_rt_i = '0;
    logic       idex_memread_i = 1'b0;
    logic [4:0] idex_rt_i = '0;
    logic       ex_multi_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o;
    logic       ex_hold_o, ex_bubble_o, busy_o;

    always #5 clk_i = ~clk_i;

    pipeline_controller #(
        .MUL_LAT (MulLat)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ex_multi_i     (ex_multi_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .ex_hold_o      (ex_hold_o),
        .ex_bubble_o    (ex_bubble_o),
        .busy_o         (busy_o)
    );

    // Output vector order: {pc_write, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ex_bubble, busy}
    localparam logic [6:0] ExpIdle   = 7'b0101000;
    localparam logic [6:0] ExpStall  = 7'b0101000;
    localparam logic [6:0] ExpBranch = 7'b1010000;
    localparam logic [6:0] ExpNormal = 7'b1000000;
    localparam logic [6:0] ExpMulHold = 7'b0100110;

    logic [6:0]  exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    bit          m_running = 1'b0;
    int          m_busy_left = 0;

    task automatic apply(input logic rst, input logic start, input logic [4:0] rs,
                         input logic [4:0] rt, input logic memread, input logic [4:0] ld_rt,
                         input logic multi, input logic br);
        logic [6:0] e;
        bit         haz;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        start_i        = start;
        ifid_rs_i      = rs;
        ifid_rt_i      = rt;
        idex_memread_i = memread;
        idex_rt_i      = ld_rt;
        ex_multi_i     = multi;
        branch_taken_i = br;
        haz = memread && (ld_rt != 5'd0) && (ld_rt == rs || ld_rt == rt);
        if (rst) begin
            e = ExpIdle;
            m_running = 1'b0;
            m_busy_left = 0;
        end else if (!m_running) begin
            e = ExpIdle;
            m_running = start;
        end else begin
            if (haz) e = ExpStall;
            else if (br) e = ExpBranch;
            else e = ExpNormal;
`ifdef PIPE_MULTICYCLE_EN
            if (m_busy_left > 1) begin
                e = ExpMulHold | 7'b0000001;
                m_busy_left = m_busy_left - 1;
            end else if (m_busy_left == 1) begin
                e[0] = 1'b1;
                m_busy_left = 0;
            end else if (multi) begin
                e = ExpMulHold;
                m_busy_left = MulLat - 1;
            end
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_in(input logic start);
        apply(1'b0, start, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk_i) begin
        logic [6:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o,
                 ex_hold_o, ex_bubble_o, busy_o};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t pc/stall/flush/bub/hold/exb/busy got %b expected %b",
                         $time, a, e);
            end
        end
    end

    initial begin
        apply(1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle_in(1'b0);
        idle_in(1'b1);
        idle_in(1'b0);
        // Load-use, then the same with a zero destination.
        apply(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0);
        idle_in(1'b0);
        apply(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        // Branch alone, then branch masked by a hazard.
        apply(1'b0, 1'b0, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1);
        idle_in(1'b0);
        apply(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b1);
        idle_in(1'b0);
        // Multi-cycle op followed immediately by a second one.
        apply(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MulLat - 1; i++) idle_in(1'b0);
        apply(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MulLat - 1; i++) idle_in(1'b0);
        idle_in(1'b0);
        // Reset while the counter is at 1, then restart.
        apply(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_in(1'b0);
        apply(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_in(1'b0);
        idle_in(1'b1);
        idle_in(1'b0);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
        end
        for (int i = 0; i < 3; i++) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencer for the five-stage pipeline: it gates the PC, stalls or flushes IF_ID, and injects bubbles into ID/EX and EX/MEM. It replaces the tied-off `flush_i` and `stall_i` constants on the pipe registers. It handles load-use hazards, taken-branch flushes and multi-cycle EX operations, and holds the pipeline frozen until `start_i`.

## Interface
- `MUL_LAT`, default 4: total EX-stage cycles of a multi-cycle op; legal range 2..16.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  run request; sampled only in IDLE.
- `ifid_rs_i`  in  5  rs field of the instruction in IF_ID.
- `ifid_rt_i`  in  5  rt field of the instruction in IF_ID.
- `idex_memread_i`  in  1  ID/EX instruction is a load.
- `idex_rt_i`  in  5  destination rt of the ID/EX load.
- `ex_multi_i`  in  1  the ID/EX instruction is a multi-cycle op (e.g. mul).
- `branch_taken_i`  in  1  branch resolved taken in ID this cycle.
- `pc_write_o`  out  1  PC may update.
- `if_id_stall_o`  out  1  IF_ID holds its contents.
- `if_id_flush_o`  out  1  IF_ID loads a nop.
- `id_ex_bubble_o`  out  1  ID/EX loads a nop.
- `ex_hold_o`  out  1  ID/EX holds its contents (multi-cycle op stays in EX).
- `ex_bubble_o`  out  1  EX/MEM loads a nop.
- `busy_o`  out  1  state is MULTI.

## Operation
- States are IDLE, RUN and MULTI. A 4-bit down-counter `cnt` is also held.
- **IDLE** (reset state)
  - Outputs: `pc_write_o`=0, `if_id_stall_o`=1, `id_ex_bubble_o`=1; all other outputs 0.
  - Goes to RUN when `start_i`=1 at the clock edge.
- **RUN**
  - Outputs are evaluated by priority; the first matching case applies.
  - Priority 1, multi-cycle op (`ex_multi_i`=1):
    - Outputs: `pc_write_o`=0, `if_id_stall_o`=1, `ex_hold_o`=1, `ex_bubble_o`=1.
    - `cnt` <= MUL_LAT-2; next state MULTI.
  - Priority 2, load-use hazard:
    - Condition: `idex_memread_i`=1, `idex_rt_i`≠0, and `idex_rt_i` equals `ifid_rs_i` or `ifid_rt_i`.
    - Outputs: `pc_write_o`=0, `if_id_stall_o`=1, `id_ex_bubble_o`=1.
  - Priority 3, taken branch (`branch_taken_i`=1):
    - Outputs: `pc_write_o`=1, `if_id_flush_o`=1.
  - Otherwise: `pc_write_o`=1; all other outputs 0.
  - A stall masks a simultaneous branch; the branch re-resolves once ID is released.
- **MULTI**
  - While `cnt`≠0: same outputs as the RUN multi-cycle stall; `cnt` decrements; `busy_o`=1.
  - When `cnt`=0: `busy_o`=1; the op leaves EX this cycle, so there is no EX hold. Hazard and branch outputs follow RUN priorities 2–3. Next state RUN.
  - `ex_multi_i` is ignored in MULTI.
- Multi-cycle totals:
  - `ex_hold_o` is asserted for exactly MUL_LAT-1 consecutive cycles.
  - The op occupies EX for MUL_LAT cycles.
- Back-to-back multi-cycle ops: the second one is detected in RUN on the cycle after the MULTI→RUN transition.
- `start_i` is a don't-care outside IDLE. Only `rst_i` returns the block to IDLE.

## Timing
- Output logic is a Mealy function of state, `cnt` and the current-cycle inputs, with zero-cycle latency; the pipe registers act on the same edge.
- State and `cnt` are registered.
- Reset (asynchronous): state=IDLE, `cnt`=0. While in reset, outputs hold the IDLE values regardless of inputs.
- Reset mid-MULTI aborts the op. The pipe registers are reset by the same `rst_i`.
- First RUN cycle is the cycle after the edge that samples `start_i`=1; `pc_write_o`=1 in that cycle.
- A load-use stall lasts exactly 1 cycle: the bubble clears the condition.
- Taken-branch flush lasts 1 cycle.

## Configuration
- `PIPE_MULTICYCLE_EN` defined:
  - MULTI state, `cnt` and `ex_multi_i` handling are present as above.
- Not defined:
  - No MULTI state or `cnt`; `ex_multi_i` is ignored.
  - `ex_hold_o`, `ex_bubble_o` and `busy_o` are tied 0.
  - `MUL_LAT` is unused.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (IDLE, RUN, MULTI), `REG_ZERO`=5'd0, and the nop encoding shared with the pipe registers.
- Sub-module `hazard_detect`: the combinational load-use compare, outputting one bit.
- FSM and counter live in `pipeline_controller`.

## Test plan
- **Reset/start:** assert `rst_i`, then release with `start_i`=0 for 5 cycles.
  - During those cycles `pc_write_o`=0, `if_id_stall_o`=1, `id_ex_bubble_o`=1.
  - After `start_i`=1, `pc_write_o`=1 on the next cycle.
- **Load-use:** `idex_memread_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8.
  - Exactly 1 cycle of `pc_write_o`=0, `if_id_stall_o`=1, `id_ex_bubble_o`=1.
  - The same stimulus with `idex_rt_i`=0 gives no stall.
- **Branch:** `branch_taken_i`=1 alone → `if_id_flush_o`=1 and `pc_write_o`=1 for 1 cycle.
  - Together with a load-use hazard → stall only, `if_id_flush_o`=0.
- **Multi-cycle, MUL_LAT=4:** `ex_multi_i`=1 for one instruction.
  - `ex_hold_o`=1 for exactly 3 cycles; `busy_o`=1 for 3 cycles.
  - Back in RUN afterwards; a second consecutive mul gives another 3-cycle hold.
- **Reset mid-MULTI:** assert `rst_i` while `cnt`=1 → immediately IDLE outputs with `busy_o`=0. After release, `start_i` is required again.
- **Macro off:** with `PIPE_MULTICYCLE_EN` undefined, `ex_multi_i`=1 causes no stall and `busy_o` stays 0.
